// File: rtl/generation_scheduler_pkg.sv
// Shared types, default widths and helpers for the Game of Life generation scheduler.
package generation_scheduler_pkg;

  localparam int unsigned GEN_W_DEF   = 16;
  localparam int unsigned SPEED_W_DEF = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } sched_state_e;

  // Frame count at which a tick fires for a given speed select: 2^speed - 1.
  function automatic int unsigned speed_to_limit(input int unsigned speed);
    return (32'd1 << speed) - 32'd1;
  endfunction

endpackage

// File: rtl/generation_scheduler_if.sv
// Control/status bundle between the scheduler and its frame, button and engine environment.
interface generation_scheduler_if #(
  parameter int unsigned GEN_W   = generation_scheduler_pkg::GEN_W_DEF,
  parameter int unsigned SPEED_W = generation_scheduler_pkg::SPEED_W_DEF
) ();

  logic               frame_start_in;
  logic               run_toggle_in;
  logic               step_in;
  logic [SPEED_W-1:0] speed_in;
  logic               logic_done_in;
  logic               gen_start_out;
  logic               running_out;
  logic               busy_out;
  logic [GEN_W-1:0]   gen_count_out;
  logic               overrun_out;

  modport master (
    input  frame_start_in, run_toggle_in, step_in, speed_in, logic_done_in,
    output gen_start_out, running_out, busy_out, gen_count_out, overrun_out
  );

  modport slave (
    output frame_start_in, run_toggle_in, step_in, speed_in, logic_done_in,
    input  gen_start_out, running_out, busy_out, gen_count_out, overrun_out
  );

endinterface

// File: rtl/generation_scheduler_frame_divider.sv
// Divides video frames down to generation ticks; tick_c fires on the frame that reaches the limit.
module generation_scheduler_frame_divider
  import generation_scheduler_pkg::*;
#(
  parameter int unsigned SPEED_W = SPEED_W_DEF
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               clear,
  input  logic               enable,
  input  logic               frame_start,
  input  logic [SPEED_W-1:0] speed,
  output logic               tick_c
);

  localparam int unsigned FDIV_W = (32'd1 << SPEED_W) - 32'd1;

  logic [FDIV_W-1:0] frame_cnt;
  logic [FDIV_W-1:0] limit;

  // Greater-or-equal compare so lowering the speed mid-count ticks on the next frame.
  always_comb begin
    limit  = FDIV_W'(speed_to_limit(32'(speed)));
    tick_c = enable & frame_start & (frame_cnt >= limit);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      frame_cnt <= '0;
    end else if (clear) begin
      frame_cnt <= '0;
    end else if (enable && frame_start) begin
      frame_cnt <= tick_c ? '0 : frame_cnt + FDIV_W'(1);
    end
  end

endmodule

// File: rtl/generation_scheduler.sv
// Schedules Game of Life generations: frame-locked free-run, pause, single-step,
// plus a completed-generation counter and a sticky overrun flag.
module generation_scheduler
  import generation_scheduler_pkg::*;
#(
  parameter int unsigned GEN_W   = GEN_W_DEF,
  parameter int unsigned SPEED_W = SPEED_W_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  generation_scheduler_if.master bus
);

  localparam logic [0:0] IDLE = ST_IDLE;
  localparam logic [0:0] BUSY = ST_BUSY;

  logic [0:0]       state,     state_nxt;
  logic             running,   running_nxt;
  logic [GEN_W-1:0] gen_count, gen_count_nxt;
  logic             overrun,   overrun_nxt;
  logic             gen_start, gen_start_nxt;

  logic tick_c;
  logic enter_run_c;
  logic engine_free_c;
  logic step_ok_c;
  logic trigger_c;

  assign enter_run_c = bus.run_toggle_in & ~running;

  generation_scheduler_frame_divider #(
    .SPEED_W (SPEED_W)
  ) u_frame_divider (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .clear       (enter_run_c),
    .enable      (running),
    .frame_start (bus.frame_start_in),
    .speed       (bus.speed_in),
    .tick_c      (tick_c)
  );

  // A done arriving this cycle frees the engine for this cycle's tick/step decision.
  always_comb begin
    engine_free_c = (state == IDLE) | bus.logic_done_in;
    step_ok_c     = bus.step_in & ~running & ~bus.run_toggle_in;
    trigger_c     = engine_free_c & (tick_c | step_ok_c);
  end

  always_comb begin
    state_nxt     = state;
    running_nxt   = running;
    gen_count_nxt = gen_count;
    overrun_nxt   = overrun;
    gen_start_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (trigger_c) state_nxt = BUSY;
      end
      BUSY: begin
        if (bus.logic_done_in) begin
          gen_count_nxt = gen_count + GEN_W'(1);
          state_nxt     = trigger_c ? BUSY : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    gen_start_nxt = trigger_c;

    if (bus.run_toggle_in) running_nxt = ~running;

    // Ticks are dropped, never queued, when the engine is still working.
    if (enter_run_c) begin
      overrun_nxt = 1'b0;
    end else if (tick_c && (state == BUSY) && !bus.logic_done_in) begin
      overrun_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      running   <= 1'b0;
      gen_count <= '0;
      overrun   <= 1'b0;
      gen_start <= 1'b0;
    end else begin
      state     <= state_nxt;
      running   <= running_nxt;
      gen_count <= gen_count_nxt;
      overrun   <= overrun_nxt;
      gen_start <= gen_start_nxt;
    end
  end

  assign bus.gen_start_out = gen_start;
  assign bus.running_out   = running;
  assign bus.busy_out      = (state == BUSY);
  assign bus.gen_count_out = gen_count;
  assign bus.overrun_out   = overrun;

endmodule

// File: tb/tb_generation_scheduler.sv
// Directed plus randomized bench for generation_scheduler against a cycle-level behavioural model.
module tb_generation_scheduler;

  logic clk_in = 1'b0;
  logic rst_in;

  always #5 clk_in = ~clk_in;

  generation_scheduler_if #(.GEN_W(16), .SPEED_W(3)) bus ();

  generation_scheduler #(.GEN_W(16), .SPEED_W(3)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_starts = 0;

  // Behavioural model state
  bit m_run, m_busy, m_ovr, m_start;
  int m_fcnt, m_gen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit tg, input bit st, input bit fr, input bit dn,
                     input logic [2:0] sp);
    int  period;
    bit  tick, free, step_ok, start;
    bit  n_run, n_busy, n_ovr;
    int  n_fcnt, n_gen;
    period  = 1 << sp;
    tick    = m_run && fr && (m_fcnt >= period - 1);
    free    = !m_busy || dn;
    step_ok = st && !m_run && !tg;
    start   = free && (tick || step_ok);
    n_gen   = (m_busy && dn) ? (m_gen + 1) % 65536 : m_gen;
    n_busy  = start ? 1'b1 : (dn ? 1'b0 : m_busy);
    n_run   = m_run ^ tg;
    n_fcnt  = m_fcnt;
    n_ovr   = m_ovr;
    if (tg && !m_run) begin
      n_fcnt = 0;
      n_ovr  = 0;
    end else begin
      if (m_run && fr) n_fcnt = tick ? 0 : m_fcnt + 1;
      if (tick && m_busy && !dn) n_ovr = 1;
    end
    if (!r) begin
      n_run = 0; n_busy = 0; n_ovr = 0; n_fcnt = 0; n_gen = 0; start = 0;
    end

    rst_in             = r;
    bus.run_toggle_in  = tg;
    bus.step_in        = st;
    bus.frame_start_in = fr;
    bus.logic_done_in  = dn;
    bus.speed_in       = sp;
    @(posedge clk_in);
    #1;
    m_run = n_run; m_busy = n_busy; m_ovr = n_ovr; m_fcnt = n_fcnt; m_gen = n_gen;
    m_start = start;

    check("gen_start", 32'(bus.gen_start_out), 32'(m_start));
    check("running",   32'(bus.running_out),   32'(m_run));
    check("busy",      32'(bus.busy_out),      32'(m_busy));
    check("gen_count", 32'(bus.gen_count_out), 32'(m_gen));
    check("overrun",   32'(bus.overrun_out),   32'(m_ovr));
    if (bus.gen_start_out === 1'b1) n_starts++;
  endtask

  task automatic idle(input int n, input logic [2:0] sp);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, sp);
  endtask

  int g0;

  initial begin
    rst_in = 1'b0;
    bus.run_toggle_in = 0; bus.step_in = 0; bus.frame_start_in = 0;
    bus.logic_done_in = 0; bus.speed_in = '0;
    m_run = 0; m_busy = 0; m_ovr = 0; m_start = 0; m_fcnt = 0; m_gen = 0;

    // Reset then idle
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    idle(20, 0);
    check("reset_gen_count", 32'(bus.gen_count_out), 32'd0);
    check("reset_busy",      32'(bus.busy_out),      32'd0);

    // Single step while paused, second step during busy is ignored
    idle(7, 0);
    cyc(1, 0, 1, 0, 0, 0);
    check("step_start", 32'(bus.gen_start_out), 32'd1);
    check("step_busy",  32'(bus.busy_out),      32'd1);
    cyc(1, 0, 0, 0, 0, 0);
    check("step_one_pulse", 32'(bus.gen_start_out), 32'd0);
    idle(3, 0);
    cyc(1, 0, 1, 0, 0, 0);
    check("step_while_busy", 32'(bus.gen_start_out), 32'd0);
    idle(3, 0);
    cyc(1, 0, 0, 0, 1, 0);
    check("done_busy",  32'(bus.busy_out),      32'd0);
    check("done_count", 32'(bus.gen_count_out), 32'd1);
    cyc(1, 0, 0, 0, 1, 0);
    check("done_idle_ignored", 32'(bus.gen_count_out), 32'd1);

    // Free-run at speed 2: a generation every 4th frame
    n_starts = 0;
    g0 = m_gen;
    cyc(1, 1, 0, 0, 0, 3'd2);
    check("run_on", 32'(bus.running_out), 32'd1);
    for (int f = 1; f <= 12; f++) begin
      cyc(1, 0, 0, 1, 0, 3'd2);
      check("frun_start", 32'(bus.gen_start_out), 32'((f % 4) == 0));
      if (bus.gen_start_out === 1'b1) begin
        idle(4, 3'd2);
        cyc(1, 0, 0, 0, 1, 3'd2);
        idle(44, 3'd2);
      end else begin
        idle(49, 3'd2);
      end
    end
    check("frun_starts",  32'(n_starts),          32'd3);
    check("frun_count",   32'(bus.gen_count_out), 32'(g0 + 3));
    check("frun_overrun", 32'(bus.overrun_out),   32'd0);

    // Overrun at speed 0 with done withheld, cleared by pause/run
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    check("ovr_first_start", 32'(bus.gen_start_out), 32'd1);
    idle(3, 0);
    cyc(1, 0, 0, 1, 0, 0);
    check("ovr_set",      32'(bus.overrun_out),   32'd1);
    check("ovr_no_start", 32'(bus.gen_start_out), 32'd0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    check("ovr_cleared", 32'(bus.overrun_out), 32'd0);

    // Done coincident with a tick while busy
    g0 = m_gen;
    cyc(1, 0, 0, 1, 1, 0);
    check("coin_start",   32'(bus.gen_start_out), 32'd1);
    check("coin_count",   32'(bus.gen_count_out), 32'((g0 + 1) % 65536));
    check("coin_overrun", 32'(bus.overrun_out),   32'd0);
    check("coin_busy",    32'(bus.busy_out),      32'd1);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 0, 0);

    // Toggle and step together while paused: toggle wins
    cyc(1, 1, 1, 0, 0, 0);
    check("tog_step_run",   32'(bus.running_out),   32'd1);
    check("tog_step_start", 32'(bus.gen_start_out), 32'd0);
    cyc(1, 1, 0, 0, 0, 0);

    // Reset mid-generation; a late done is ignored
    cyc(1, 0, 1, 0, 0, 0);
    check("mid_busy", 32'(bus.busy_out), 32'd1);
    cyc(0, 0, 0, 0, 0, 0);
    check("mid_rst_busy",  32'(bus.busy_out),      32'd0);
    check("mid_rst_count", 32'(bus.gen_count_out), 32'd0);
    cyc(1, 0, 0, 0, 1, 0);
    check("late_done_count", 32'(bus.gen_count_out), 32'd0);
    check("late_done_busy",  32'(bus.busy_out),      32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(499) != 0),
          ($urandom_range(39) == 0),
          ($urandom_range(9) == 0),
          ($urandom_range(7) == 0),
          ($urandom_range(5) == 0),
          3'($urandom_range(7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/generation_scheduler.md
Name: generation_scheduler

Overview:
- Decides when the Game of Life logic engine computes the next generation. Supports free-run at a selectable rate locked to video frames, pause, and single-step.
- Sits upstream of the synchronizer. gen_start_out is the request that the synchronizer turns into logic_start. logic_done_in is the engine's completion pulse.
- Also keeps a generation counter for display and a sticky overrun flag for debug LEDs.

Parameters:
- GEN_W, 16, width of generation counter.
- SPEED_W, 3, width of speed select; tick period = 2^speed_in frames, so 1..128 frames at default.
- FDIV_W, derived = 2^SPEED_W - 1 (7 at default), width of frame divider counter; not user-overridden.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, synchronous, active-low.
- frame_start_in  input  1  one-cycle pulse at start of each video frame.
- run_toggle_in  input  1  one-cycle debounced pulse; toggles run/pause.
- step_in  input  1  one-cycle debounced pulse; request one generation while paused.
- speed_in  input  SPEED_W  rate select; generation every 2^speed_in frames.
- logic_done_in  input  1  one-cycle pulse; current generation finished.
- gen_start_out  output  1  one-cycle pulse; start one generation.
- running_out  output  1  1 = free-run mode, 0 = paused.
- busy_out  output  1  generation in flight.
- gen_count_out  output  GEN_W  completed generations, wraps.
- overrun_out  output  1  sticky; a scheduled tick found the engine busy.

Behaviour:
- Reset (rst_in low at rising edge):
  - running=0, state=IDLE, frame_cnt=0, gen_count=0, overrun=0, gen_start_out=0.
  - Takes effect mid-generation too; a logic_done_in arriving after reset while IDLE is ignored.
- FSM, two states, busy_out = (state==BUSY):
  - IDLE -> BUSY on trigger.
  - BUSY -> IDLE on logic_done_in.
- Trigger: the cycle after a trigger condition, gen_start_out=1 for exactly one cycle and state=BUSY. Latency is 1 cycle, all outputs registered.
- Run toggle:
  - run_toggle_in flips running next cycle.
  - Entering run clears frame_cnt and overrun.
  - Leaving run does not abort an in-flight generation.
- Frame divider (running only):
  - On frame_start_in: if frame_cnt >= (2^speed_in)-1, this is a tick and frame_cnt<=0. Otherwise frame_cnt<=frame_cnt+1.
  - frame_cnt holds when paused.
  - speed_in is sampled on every frame_start_in compare. Lowering speed below the current count gives a tick at the next frame; there is no wrap-around stall.
- Tick while IDLE: trigger.
- Tick while BUSY with no same-cycle done: overrun<=1 and the tick is dropped, never queued.
- Step: trigger only when running=0, state=IDLE and run_toggle_in=0. It is ignored while running, while busy, or when coincident with a toggle (toggle wins).
- logic_done_in while BUSY: state<=IDLE, gen_count<=gen_count+1 mod 2^GEN_W.
- logic_done_in while IDLE: ignored, no count change.
- Done coincident with tick or step in the same cycle: done completes, and the engine is treated as IDLE for that evaluation. The trigger is honoured: next cycle gen_start_out=1, state=BUSY, count incremented, no overrun.
- frame_start_in and step_in simultaneous while paused: step honoured, frame ignored.

Decomposition:
- sched_pkg:
  - state enum: IDLE, BUSY.
  - localparams GEN_W_DEF=16, SPEED_W_DEF=3.
  - function speed_to_limit(speed) returning (1<<speed)-1.
- Sub-module frame_divider: counter with clear and enable, speed compare, tick output.
- Top: FSM, run flag, step/toggle priority, counter, overrun.

Test Plan:
- Reset then idle: rst_in low 2 cycles, then high, no other inputs -> all outputs 0 for 20 cycles, gen_count_out=0.
- Single step: paused, step_in pulse at cycle 10 -> gen_start_out=1 at cycle 11 only, busy_out=1. Then logic_done_in at cycle 20 -> busy_out=0, gen_count_out=1 at cycle 21. A second step_in during busy -> no gen_start_out.
- Free-run rate: speed_in=2, toggle run, frame_start_in every 50 cycles, done 5 cycles after each start -> gen_start_out after frames 4, 8, 12. gen_count_out=3 after third done. overrun_out=0.
- Overrun: speed_in=0, run, done withheld across 2 frames -> first frame starts a generation, second frame sets overrun_out=1 with no extra start. Toggle pause then run -> overrun_out=0.
- Coincidence: done and frame tick in the same cycle while BUSY -> gen_start_out next cycle, gen_count incremented by 1, overrun_out stays 0. Toggle and step in the same cycle while paused -> running_out=1, no gen_start_out.
- Reset mid-generation: start, then rst_in low while BUSY -> busy_out=0, gen_count_out=0. A later logic_done_in has no effect.
